// File: rtl/qubo_problem_loader.sv
// qubo_problem_loader: decodes a byte-wide command stream into writes to the
// QUBO coupling memory and a start pulse for the solver.
//   clk, rst_n         clock / async active-low reset
//   in_data, in_valid  command/data byte stream (in_ready = byte accepted)
//   solver_idle        downstream solver is idle
//   wr_en/addr/data    coupling-memory write port (registered)
//   start              solver start pulse, raised in WAIT_IDLE when the solver is idle
//   write_count        saturating count of weight writes (CLEAR not counted)
module qubo_problem_loader #(
  parameter int unsigned N_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  solver_idle,
  output logic                  wr_en,
  output logic [2*N_LOG2-1:0]   wr_addr,
  output logic [7:0]            wr_data,
  output logic                  start,
  output logic [7:0]            write_count
);

  localparam int unsigned AW = 2 * N_LOG2;

  localparam logic [1:0] OP_NOP   = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_CLEAR = 2'b10;
  localparam logic [1:0] OP_START = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    GET_WEIGHT,
    WRITE_A,
    WRITE_B,
    CLEAR,
    WAIT_IDLE
  } state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     addr_q, addr_d;
  logic              sym_q, sym_d;
  logic              wr_en_d;
  logic [AW-1:0]     wr_addr_d;
  logic [7:0]        wr_data_d;
  logic              in_ready_d;
  logic [7:0]        count_d;
  logic [7:0]        count_inc;
  logic              accept;
  logic [N_LOG2-1:0] row, col;
  logic              unused_in_bits;

  assign accept    = in_valid && in_ready;
  assign row       = addr_q[AW-1:N_LOG2];
  assign col       = addr_q[N_LOG2-1:0];
  assign count_inc = (write_count == 8'hFF) ? write_count : write_count + 8'd1;
  // Bit 5 and high address bits of a WRITE opcode carry no meaning.
  assign unused_in_bits = ^in_data;

  // start is decoded from the state register so it can fire in the same
  // cycle solver_idle is seen; it can never coincide with wr_en.
  assign start = (state_q == WAIT_IDLE) && solver_idle;

  // State and registered-output update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      sym_q       <= 1'b0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      in_ready    <= 1'b1;
      write_count <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      sym_q       <= sym_d;
      wr_en       <= wr_en_d;
      wr_addr     <= wr_addr_d;
      wr_data     <= wr_data_d;
      in_ready    <= in_ready_d;
      write_count <= count_d;
    end
  end

  // Next-state and next-output decode; outputs are computed for the state
  // being entered so they line up with it after the edge.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    sym_d     = sym_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr;
    wr_data_d = wr_data;
    count_d   = write_count;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          unique case (in_data[7:6])
            OP_NOP: ;
            OP_WRITE: begin
              addr_d  = in_data[AW-1:0];
              sym_d   = in_data[4];
              state_d = GET_WEIGHT;
            end
            OP_CLEAR: begin
              state_d   = CLEAR;
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = '0;
              count_d   = '0;
            end
            OP_START: state_d = WAIT_IDLE;
            default: ;
          endcase
        end
      end
      GET_WEIGHT: begin
        if (accept) begin
          state_d   = WRITE_A;
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = in_data;
          count_d   = count_inc;
        end
      end
      WRITE_A: begin
        // Mirror write only for off-diagonal symmetric entries.
        if (sym_q && (row != col)) begin
          state_d   = WRITE_B;
          wr_en_d   = 1'b1;
          wr_addr_d = {col, row};
          count_d   = count_inc;
        end else begin
          state_d = IDLE;
        end
      end
      WRITE_B: state_d = IDLE;
      CLEAR: begin
        // wr_addr doubles as the sweep counter.
        if (wr_addr == {AW{1'b1}}) begin
          state_d = IDLE;
        end else begin
          wr_en_d   = 1'b1;
          wr_addr_d = wr_addr + AW'(1);
          wr_data_d = '0;
        end
      end
      WAIT_IDLE: begin
        if (solver_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE) || (state_d == GET_WEIGHT);
  end

endmodule

// File: doc/qubo_problem_loader.md
QUBO_PROBLEM_LOADER -- requirements
Module: qubo_problem_loader

Interface
REQ-001 The block SHALL have one parameter: N_LOG2, default 2, log2 of the spin count N (legal values 1..2).
REQ-002 The block SHALL use one clock; reset SHALL be asynchronous and active-low.
REQ-003 The block SHALL have the following ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- in_data  in  8  command/data byte stream
- in_valid  in  1  in_data valid
- in_ready  out  1  loader accepts a byte this cycle
- solver_idle  in  1  downstream QUBO solver is idle
- wr_en  out  1  one-cycle coupling-memory write strobe
- wr_addr  out  2*N_LOG2  write address = row*N + col
- wr_data  out  8  signed coupling weight Q[row][col]
- start  out  1  one-cycle solver start pulse
- write_count  out  8  saturating count of weight writes

Function
REQ-004 A byte SHALL be accepted on a rising edge where in_valid and in_ready are both 1; no other byte is consumed.
REQ-005 The opcode byte SHALL be decoded from bits [7:6]: 00 NOP, 01 WRITE, 10 CLEAR, 11 START.
REQ-006 In a WRITE opcode, bit 4 SHALL be the SYM flag, bit 5 SHALL be ignored, and bits [2*N_LOG2-1:0] SHALL be the address: row = upper N_LOG2 bits, col = lower N_LOG2 bits.
REQ-007 Unused low address bits SHALL be ignored.
REQ-008 The FSM SHALL have exactly these states: IDLE, GET_WEIGHT, WRITE_A, WRITE_B, CLEAR, WAIT_IDLE.
REQ-009 in_ready SHALL be 1 only in IDLE and GET_WEIGHT.
REQ-010 In IDLE, an accepted NOP SHALL be discarded and the FSM SHALL stay in IDLE.
REQ-011 In IDLE, an accepted WRITE SHALL latch the address and SYM flag and go to GET_WEIGHT.
REQ-012 In GET_WEIGHT, the next accepted byte SHALL be latched as the weight, and the FSM SHALL go to WRITE_A.
REQ-013 In WRITE_A, the block SHALL assert wr_en for one cycle with wr_addr = row*N+col and wr_data = weight.
REQ-014 After WRITE_A, the FSM SHALL go to WRITE_B if SYM=1 and row != col; otherwise it SHALL go to IDLE.
REQ-015 In WRITE_B, the block SHALL assert wr_en for one cycle with wr_addr = col*N+row and the same wr_data, then go to IDLE.
REQ-016 A diagonal entry (row = col) with SYM=1 SHALL produce exactly one write.
REQ-017 An accepted CLEAR SHALL enter the CLEAR state.
REQ-018 In CLEAR, the block SHALL assert wr_en on N*N consecutive cycles, with wr_addr 0,1,...,N*N-1 and wr_data = 0, then return to IDLE.
REQ-019 CLEAR SHALL reset write_count to 0.
REQ-020 An accepted START SHALL enter WAIT_IDLE.
REQ-021 In WAIT_IDLE, on the first cycle where solver_idle = 1, start SHALL be 1 for exactly that cycle and the FSM SHALL return to IDLE.
REQ-022 If solver_idle = 1 already on the cycle after acceptance, start SHALL pulse on that cycle, giving a latency of 1 cycle.
REQ-023 write_count SHALL increment by 1 per wr_en pulse in WRITE_A or WRITE_B, and SHALL saturate at 255.
REQ-024 CLEAR pulses SHALL NOT be counted in write_count.
REQ-025 wr_en and start SHALL never be 1 in the same cycle.
REQ-026 wr_en SHALL be 0 in IDLE, GET_WEIGHT and WAIT_IDLE.
REQ-027 wr_addr and wr_data SHALL be don't-care when wr_en = 0, but SHALL be registered (glitch-free).
REQ-028 in_valid while in_ready = 0 SHALL have no effect; the upstream source holds the byte.

Reset
REQ-029 On rst_n = 0, the block SHALL immediately (asynchronously) enter IDLE.
REQ-030 On reset, wr_en, start, wr_addr, wr_data and write_count SHALL be 0, and in_ready SHALL be 1.
REQ-031 A reset during GET_WEIGHT, WRITE_A/B, CLEAR or WAIT_IDLE SHALL abort the operation with no further wr_en or start pulses.
REQ-032 After reset release, the first byte SHALL be decoded as an opcode.

Verification (N_LOG2=2)
REQ-033 Reset check: assert rst_n=0 mid-cycle -> all outputs 0 and in_ready=1 at once, with no clock edge needed.
REQ-034 Single write: send 0x46 then 0xF3 -> exactly one wr_en pulse one cycle after the 0xF3 is accepted, with wr_addr=6 and wr_data=0xF3; write_count=1.
REQ-035 Symmetric write: send 0x56 then 0x05 -> wr_en pulses on two consecutive cycles, wr_addr=6 then 9, wr_data=0x05 on both; write_count increases by 2.
REQ-036 Diagonal symmetric write: send 0x55 then 0x80 -> exactly one pulse, with wr_addr=5 and wr_data=0x80.
REQ-037 Clear: send 0x80 -> 16 consecutive pulses with wr_addr 0..15 and wr_data 0; in_ready=0 for those 16 cycles; write_count=0 afterwards.
REQ-038 Clear aborted by reset: send 0x80, then pulse rst_n=0 after 5 pulses -> no pulses after reset; next byte 0xC0 is decoded as START.
REQ-039 Start gated by solver: send 0xC0 with solver_idle=0 for 5 cycles -> start=0 and in_ready=0 throughout; raise solver_idle -> start=1 for exactly one cycle; in_ready=1 on the next cycle.
REQ-040 Saturation: perform 300 single writes -> write_count holds at 255.
